// File: rtl/r2n_buffer_o.sv
// r2n_buffer_o: gathers BLOCK_SIZE x BLOCK_SIZE result blocks into two ping-pong
// strips of BLOCK_SIZE full rows each and emits them as row-major rows.
// Column 0 of a row sits in the MSB slice of out_row.
module r2n_buffer_o #(
  parameter int WIDTH      = 16,
  parameter int ROW        = 256,
  parameter int COL        = 64,
  parameter int BLOCK_SIZE = 2,
  parameter int IN_WIDTH   = WIDTH*BLOCK_SIZE*BLOCK_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*COL-1:0]    out_row,
  output logic [$clog2(ROW)-1:0]  out_row_idx,
  output logic                    done
);

  localparam int NCB    = COL/BLOCK_SIZE;
  localparam int CBW    = (NCB > 1) ? $clog2(NCB) : 1;
  localparam int SRW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int NSTRIP = ROW/BLOCK_SIZE;
  localparam int SCW    = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;
  localparam int RW     = $clog2(ROW);
  localparam int CIW    = $clog2(COL);

  typedef enum logic [1:0] {D_IDLE, D_EMIT, D_DONE} dstate_t;

  // [strip][row][col][bit]; col index COL-1 holds matrix column 0 so a stored
  // row is already in output order.
  logic [1:0][BLOCK_SIZE-1:0][COL-1:0][WIDTH-1:0] strip;

  logic [1:0]                    full;
  logic                          wr_sel, rd_sel;
  logic [CBW-1:0]                col_blk;
  logic [SCW-1:0]                strip_cnt;
  logic                          fill_done;   // every strip of the frame has been filled
  logic [SRW-1:0]                sub_row;
  logic [RW-1:0]                 row_cnt;
  dstate_t                       state;
  logic [BLOCK_SIZE-1:0][CIW-1:0] wcol;

  logic accept, last_blk, last_sub, last_strip, last_row;

  // fill_done keeps a drained strip from soaking up blocks beyond the frame
  assign in_ready    = !full[wr_sel] && !fill_done && !done && !rst;
  assign accept      = in_valid && in_ready;
  assign last_blk    = (col_blk == CBW'(NCB-1));
  assign last_sub    = (sub_row == SRW'(BLOCK_SIZE-1));
  assign last_strip  = (strip_cnt == SCW'(NSTRIP-1));
  assign last_row    = (row_cnt == RW'(ROW-1));
  assign out_row_idx = row_cnt;

  // storage column for each block column c of the current col_blk
  for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_wcol
    assign wcol[c] = CIW'(COL - 1 - c - BLOCK_SIZE*int'(col_blk));
  end

  // strip data: written on block acceptance, no reset needed
  always_ff @(posedge clk) begin
    if (accept)
      for (int r = 0; r < BLOCK_SIZE; r++)
        for (int c = 0; c < BLOCK_SIZE; c++)
          strip[wr_sel][r][wcol[c]] <= in_data[(r*BLOCK_SIZE+c)*WIDTH +: WIDTH];
  end

  // fill bookkeeping and drain FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      col_blk   <= '0;
      strip_cnt <= '0;
      fill_done <= 1'b0;
      sub_row   <= '0;
      row_cnt   <= '0;
      state     <= D_IDLE;
      out_valid <= 1'b0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        if (last_blk) begin
          col_blk      <= '0;
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          strip_cnt    <= strip_cnt + 1'b1;
          if (last_strip) fill_done <= 1'b1;
        end else begin
          col_blk <= col_blk + 1'b1;
        end
      end

      case (state)
        D_IDLE: begin
          if (full[rd_sel]) begin
            state     <= D_EMIT;
            sub_row   <= '0;
            out_valid <= 1'b1;
            out_row   <= strip[rd_sel][0];
          end
        end
        D_EMIT: begin
          if (out_ready) begin
            row_cnt <= row_cnt + 1'b1;
            if (!last_sub) begin
              sub_row <= sub_row + 1'b1;
              out_row <= strip[rd_sel][sub_row + 1'b1];
            end else begin
              full[rd_sel] <= 1'b0;
              rd_sel       <= !rd_sel;
              sub_row      <= '0;
              if (last_row) begin
                state     <= D_DONE;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else if (full[!rd_sel]) begin
                out_row <= strip[!rd_sel][0];
              end else begin
                state     <= D_IDLE;
                out_valid <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r2n_buffer_o.sv
// Bench for r2n_buffer_o: a 4x4 instance for directed table-driven checks and
// an 8x8 instance for ping-pong overlap and randomized frames against a
// matrix-level reference (rows of the source matrix).
module tb_r2n_buffer_o;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- 4x4 instance ----------------
  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_done;
  logic [63:0] a_in_data, a_out_row;
  logic [1:0]  a_idx;

  r2n_buffer_o #(.WIDTH(16), .ROW(4), .COL(4), .BLOCK_SIZE(2), .IN_WIDTH(64)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_row(a_out_row), .out_row_idx(a_idx), .done(a_done));

  typedef struct packed { logic [63:0] blk; logic [63:0] row; } vec_t;
  vec_t tv [4];

  function automatic logic [63:0] offs(input logic [63:0] x, input int o);
    logic [63:0] y;
    for (int i = 0; i < 4; i++) y[i*16 +: 16] = x[i*16 +: 16] + 16'(o);
    return y;
  endfunction

  int ra_blk, ra_rows, ra_first_v, ra_acc1, ra_first_e, ra_last_e;
  logic [63:0] ra_snap_row;
  logic ra_snap_v, ra_snap_ir;

  task automatic reset_a();
    a_rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_in_ready", 128'(a_in_ready), 128'(0));
    chk("a_rst_state", {a_out_valid, a_done, a_idx, a_out_row}, 128'(0));
    a_rst = 1'b0;
    #1;
    chk("a_in_ready_after_rst", 128'(a_in_ready), 128'(1));
  endtask

  // stream up to max_blk blocks (offering junk beyond a full frame), out_ready
  // held low for hold cycles, rows checked against table plus offset
  task automatic run_a(input int base, input int hold, input int max_blk, input int budget);
    logic acc;
    ra_blk = 0; ra_rows = 0; ra_first_v = -1; ra_acc1 = -1; ra_first_e = -1; ra_last_e = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      a_in_valid  = (ra_blk < max_blk) || (max_blk == 4);
      a_in_data   = (ra_blk < 4) ? offs(tv[ra_blk].blk, base) : 64'hdead_beef_dead_beef;
      a_out_ready = (cyc >= hold);
      @(negedge clk);
      if (cyc == hold - 1) begin
        ra_snap_row = a_out_row; ra_snap_v = a_out_valid; ra_snap_ir = a_in_ready;
      end
      if (a_out_valid && ra_first_v < 0) ra_first_v = cyc;
      if (a_out_valid && a_out_ready) begin
        if (ra_rows < 4) begin
          chk("a_row", 128'(a_out_row), 128'(offs(tv[ra_rows].row, base)));
          chk("a_row_idx", 128'(a_idx), 128'(ra_rows));
        end else begin
          chk("a_extra_row", 128'(ra_rows), 128'(3));
        end
        if (ra_first_e < 0) ra_first_e = cyc;
        ra_last_e = cyc;
        ra_rows++;
      end
      acc = a_in_valid && a_in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (ra_blk == 1) ra_acc1 = cyc;
        ra_blk++;
      end
    end
  endtask

  // ---------------- 8x8 instance ----------------
  logic         b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
  logic [63:0]  b_in_data;
  logic [127:0] b_out_row;
  logic [2:0]   b_idx;

  r2n_buffer_o #(.WIDTH(16), .ROW(8), .COL(8), .BLOCK_SIZE(2), .IN_WIDTH(64)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_row(b_out_row), .out_row_idx(b_idx), .done(b_done));

  logic [15:0] bm [8][8];

  // block k of the block-row-major stream cut out of matrix bm
  function automatic logic [63:0] mkblk(input int k);
    logic [63:0] d;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        d[(r*2+c)*16 +: 16] = bm[(k/4)*2 + r][(k%4)*2 + c];
    return d;
  endfunction

  // matrix row r with column 0 in the MSB
  function automatic logic [127:0] mkrow(input int r);
    logic [127:0] d;
    for (int c = 0; c < 8; c++) d[(7-c)*16 +: 16] = bm[r][c];
    return d;
  endfunction

  task automatic run_b(input int mode);
    int blk, rows, overlap, seen_done;
    logic acc, emit, pend;
    logic [127:0] prow;
    logic [2:0] pidx;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) bm[r][c] = 16'($urandom);
    b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    blk = 0; rows = 0; overlap = 0; seen_done = -1; pend = 1'b0; prow = '0; pidx = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (mode == 0) begin
        b_in_valid  = 1'b1;
        b_out_ready = (cyc % 2 == 0);
      end else begin
        b_in_valid  = 1'($urandom_range(0, 1));
        b_out_ready = ($urandom_range(0, 2) != 0);
      end
      b_in_data = (blk < 16) ? mkblk(blk) : {$urandom, $urandom};
      @(negedge clk);
      if (pend)
        chk("b_hold_stable", {b_out_valid, b_idx, b_out_row}, {1'b1, pidx, prow});
      pend = b_out_valid && !b_out_ready;
      prow = b_out_row; pidx = b_idx;
      emit = b_out_valid && b_out_ready;
      if (emit) begin
        if (rows < 8) begin
          chk("b_row", b_out_row, mkrow(rows));
          chk("b_row_idx", 128'(b_idx), 128'(rows));
        end else begin
          chk("b_extra_row", 128'(rows), 128'(7));
        end
        rows++;
      end
      acc = b_in_valid && b_in_ready;
      if (acc && emit) overlap++;
      if (b_done && seen_done < 0) seen_done = cyc;
      @(posedge clk);
      #1;
      if (acc) blk++;
      if (seen_done >= 0 && cyc > seen_done + 5) break;
    end
    chk("b_done_seen", 128'(seen_done >= 0), 128'(1));
    chk("b_blocks_accepted", 128'(blk), 128'(16));
    chk("b_rows_emitted", 128'(rows), 128'(8));
    if (mode == 0) chk("b_fill_drain_overlap", 128'(overlap > 0), 128'(1));
  endtask

  initial begin
    tv[0] = '{blk: 64'h0005_0004_0001_0000, row: 64'h0000_0001_0002_0003};
    tv[1] = '{blk: 64'h0007_0006_0003_0002, row: 64'h0004_0005_0006_0007};
    tv[2] = '{blk: 64'h000d_000c_0009_0008, row: 64'h0008_0009_000a_000b};
    tv[3] = '{blk: 64'h000f_000e_000b_000a, row: 64'h000c_000d_000e_000f};
    a_rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

    // basic frame + latency + done/excess
    reset_a();
    run_a(0, 0, 4, 20);
    chk("a_basic_blocks", 128'(ra_blk), 128'(4));
    chk("a_basic_rows", 128'(ra_rows), 128'(4));
    chk("a_latency", 128'(ra_first_v), 128'(ra_acc1 + 2));
    chk("a_done_state", {a_done, a_in_ready, a_out_valid}, {1'b1, 1'b0, 1'b0});

    // reset clears done; backpressure with out_ready low for 12 cycles
    reset_a();
    run_a(0, 12, 4, 24);
    chk("a_bp_blocks", 128'(ra_blk), 128'(4));
    chk("a_bp_held_row", {ra_snap_v, ra_snap_ir, ra_snap_row}, {1'b1, 1'b0, tv[0].row});
    chk("a_bp_first_emit", 128'(ra_first_e), 128'(12));
    chk("a_bp_last_emit", 128'(ra_last_e), 128'(15));
    chk("a_bp_rows", 128'(ra_rows), 128'(4));

    // reset mid-frame after 3 blocks, then a fresh frame offset by 100
    reset_a();
    run_a(0, 100, 3, 8);
    chk("a_partial_blocks", 128'(ra_blk), 128'(3));
    reset_a();
    run_a(100, 0, 4, 20);
    chk("a_new_frame_rows", 128'(ra_rows), 128'(4));
    chk("a_new_frame_done", 128'(a_done), 128'(1));

    // ping-pong overlap with toggling out_ready, then random frames
    run_b(0);
    for (int f = 0; f < 150; f++) run_b(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
